rv32i_run_ctrl: RTL and testbench

- Synthesizable run controller for the rv32i_core.
- Sequences the core reset for a configurable number of back-to-back runs.
- Counts cycles per run and watches core RAM writes for a tohost completion write.
- Flags pass, fail or timeout. Replaces hand-timed reset sequencing in benches and FPGA harnesses with a deterministic FSM.

---
 rtl/rv32i_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rv32i_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_run_ctrl.sv
// Run controller for rv32i_core: reset sequencing, tohost watch, pass/fail/timeout.
// Optional write signature enabled with `define RUN_CTRL_SIG_EN.
module rv32i_run_ctrl #(
   parameter int unsigned         DATA_W         = 32,
   parameter int unsigned         ADDR_W         = 32,
   parameter logic [ADDR_W-1:0]   TOHOST_ADDR    = 32'h0000_1000,
   parameter int unsigned         RESET_CYCLES   = 16,
   parameter int unsigned         TIMEOUT_CYCLES = 1000000,
   parameter int unsigned         CNT_W          = 32,
   parameter int unsigned         NUM_RUNS       = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] ram_addr_i,
   input  logic [DATA_W-1:0] ram_data_i,
   input  logic              ram_rw_i,
   output logic              core_reset_o,
   output logic              running_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic              timeout_o,
   output logic [DATA_W-2:0] exit_code_o,
   output logic [7:0]        run_idx_o,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic [DATA_W-1:0] sig_o
);

   localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        LAST_IDX  = 8'(NUM_RUNS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          idx_q, idx_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic                to_q, to_d;
   logic [DATA_W-2:0]   exit_q, exit_d;
   logic                tohost;

`ifdef RUN_CTRL_SIG_EN
   logic [DATA_W-1:0]   sig_q, sig_d;
`endif

   assign tohost = ram_rw_i && (ram_addr_i == TOHOST_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         to_q    <= 1'b0;
         exit_q  <= '0;
`ifdef RUN_CTRL_SIG_EN
         sig_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         exit_q  <= exit_d;
`ifdef RUN_CTRL_SIG_EN
         sig_q   <= sig_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      to_d    = to_q;
      exit_d  = exit_q;
`ifdef RUN_CTRL_SIG_EN
      sig_d   = sig_q;
`endif
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_HOLD;
               hold_d  = '0;
               idx_d   = '0;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
               to_d    = 1'b0;
               exit_d  = '0;
`ifdef RUN_CTRL_SIG_EN
               sig_d   = '0;
`endif
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_RUN: begin
`ifdef RUN_CTRL_SIG_EN
            if (ram_rw_i)
               sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]}
                     ^ ram_data_i ^ ram_addr_i[DATA_W-1:0];
`endif
            // A tohost result on the timeout cycle wins; the counter freezes on exit.
            if (tohost && ram_data_i == DATA_W'(1)) begin
               if (idx_q == LAST_IDX) begin
                  pass_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  hold_d  = '0;
                  state_d = S_HOLD;
`ifdef RUN_CTRL_SIG_EN
                  sig_d   = '0;
`endif
               end
            end else if (tohost && ram_data_i[0]) begin
               fail_d  = 1'b1;
               exit_d  = ram_data_i[DATA_W-1:1];
               state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      core_reset_o = (state_q != S_RUN);
      running_o    = (state_q == S_RUN);
      done_o       = (state_q == S_DONE);
   end

   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign timeout_o   = to_q;
   assign exit_code_o = exit_q;
   assign run_idx_o   = idx_q;
   assign cycle_cnt_o = cnt_q;

`ifdef RUN_CTRL_SIG_EN
   assign sig_o = sig_q;
`else
   assign sig_o = '0;
`endif

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Scoreboard bench for rv32i_run_ctrl (RESET_CYCLES=4, TIMEOUT_CYCLES=50, NUM_RUNS=2).
module tb_rv32i_run_ctrl;

   localparam int RC = 4;

   typedef struct {
      logic        p;
      logic        f;
      logic        t;
      logic [30:0] ex;
      logic [7:0]  idx;
      logic [31:0] cnt;
      int          rl;
      logic [31:0] sig;
   } done_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [31:0] ram_addr_i;
   logic [31:0] ram_data_i;
   logic        ram_rw_i;
   logic        core_reset_o;
   logic        running_o;
   logic        done_o;
   logic        pass_o;
   logic        fail_o;
   logic        timeout_o;
   logic [30:0] exit_code_o;
   logic [7:0]  run_idx_o;
   logic [31:0] cycle_cnt_o;
   logic [31:0] sig_o;

   int total = 0;
   int bad   = 0;

   done_t      done_q[$];
   logic [7:0] entry_q[$];

   rv32i_run_ctrl #(
      .DATA_W(32), .ADDR_W(32), .TOHOST_ADDR(32'h0000_1000),
      .RESET_CYCLES(RC), .TIMEOUT_CYCLES(50), .CNT_W(32), .NUM_RUNS(2)
   ) dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_rw_i(ram_rw_i),
      .core_reset_o(core_reset_o), .running_o(running_o), .done_o(done_o),
      .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
      .exit_code_o(exit_code_o), .run_idx_o(run_idx_o),
      .cycle_cnt_o(cycle_cnt_o), .sig_o(sig_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sig_step(logic [31:0] s, logic [31:0] a,
                                            logic [31:0] d);
      return {s[30:0], s[31]} ^ d ^ a;
   endfunction

   function automatic logic [31:0] sig_exp(logic [31:0] s);
`ifdef RUN_CTRL_SIG_EN
      return s;
`else
      return (s & 32'h0);
`endif
   endfunction

   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   // monitor: pops expectations on run entry and on DONE entry
   int  hc    = 0;
   int  rl    = 0;
   bit  prun  = 0;
   bit  pdone = 0;

   always @(negedge clk) begin
      if (!reset) begin
         hc = 0; rl = 0; prun = 0; pdone = 0;
      end else begin
         if (running_o && !prun) begin
            if (entry_q.size() == 0) begin
               total++; bad++;
               $display("FAIL entry: unexpected run entry idx=%0d", run_idx_o);
            end else begin
               logic [7:0] ei;
               ei = entry_q.pop_front();
               chk("hold_len", 32'(hc), 32'(RC));
               chk("entry_idx", 32'(run_idx_o), 32'(ei));
               chk("entry_cnt", cycle_cnt_o, 32'd0);
               chk("entry_crst", 32'(core_reset_o), 32'd0);
            end
            rl = 0;
         end
         if (running_o) rl++;
         if (done_o && !pdone) begin
            if (done_q.size() == 0) begin
               total++; bad++;
               $display("FAIL done: unexpected done");
            end else begin
               done_t e;
               e = done_q.pop_front();
               chk("pass", 32'(pass_o), 32'(e.p));
               chk("fail", 32'(fail_o), 32'(e.f));
               chk("timeout", 32'(timeout_o), 32'(e.t));
               chk("exit", 32'(exit_code_o), 32'(e.ex));
               chk("run_idx", 32'(run_idx_o), 32'(e.idx));
               chk("cycle_cnt", cycle_cnt_o, e.cnt);
               chk("run_len", 32'(rl), 32'(e.rl));
               chk("sig", sig_o, e.sig);
               chk("done_crst", 32'(core_reset_o), 32'd1);
               chk("done_run", 32'(running_o), 32'd0);
            end
         end
         if (start_i || running_o || done_o) hc = 0;
         else hc++;
         prun  = running_o;
         pdone = done_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_run();
      int n = 0;
      while (!running_o && n < 100) begin
         tick();
         n++;
      end
      if (!running_o) begin
         total++; bad++;
         $display("FAIL wait_run: running_o=0 want 1 after 100 cycles");
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_o && n < 200) begin
         tick();
         n++;
      end
      if (!done_o) begin
         total++; bad++;
         $display("FAIL wait_done: done_o=0 want 1 after 200 cycles");
      end
      tick();
   endtask

   task automatic wr_at(int c, logic [31:0] a, logic [31:0] d);
      repeat (c) tick();
      ram_rw_i   = 1'b1;
      ram_addr_i = a;
      ram_data_i = d;
      tick();
      ram_rw_i   = 1'b0;
      ram_addr_i = '0;
      ram_data_i = '0;
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_crst"}, 32'(core_reset_o), 32'd1);
      chk({tag, "_run"}, 32'(running_o), 32'd0);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_flags"}, {29'd0, pass_o, fail_o, timeout_o}, 32'd0);
      chk({tag, "_exit"}, 32'(exit_code_o), 32'd0);
      chk({tag, "_idx"}, 32'(run_idx_o), 32'd0);
      chk({tag, "_cnt"}, cycle_cnt_o, 32'd0);
      chk({tag, "_sig"}, sig_o, 32'd0);
   endtask

   function automatic done_t mk(logic p, logic f, logic t, logic [30:0] ex,
                                logic [7:0] idx, logic [31:0] cnt, int rlen,
                                logic [31:0] s);
      done_t r;
      r.p = p; r.f = f; r.t = t; r.ex = ex; r.idx = idx;
      r.cnt = cnt; r.rl = rlen; r.sig = sig_exp(s);
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start_i = 1'b0;
      ram_rw_i = 1'b0; ram_addr_i = '0; ram_data_i = '0;
      repeat (2) tick();
      chk_reset("por");
      reset = 1'b1;
      tick();

      // two passing runs; signature from a non-tohost write then the pass
      entry_q.push_back(8'd0);
      entry_q.push_back(8'd1);
      done_q.push_back(mk(1, 0, 0, 31'd0, 8'd1, 32'd5, 6,
         sig_step(sig_step(32'h0, 32'h2000, 32'hA5), 32'h1000, 32'h1)));
      do_start();
      wait_run();
      wr_at(10, 32'h1000, 32'h1);
      wait_run();
      wr_at(3, 32'h2000, 32'hA5);
      wr_at(1, 32'h1000, 32'h1);
      wait_done();

      // fail on run 0, restart from DONE
      entry_q.push_back(8'd0);
      done_q.push_back(mk(0, 1, 0, 31'd21, 8'd0, 32'd7, 8,
         sig_step(32'h0, 32'h1000, 32'h2B)));
      do_start();
      wait_run();
      wr_at(7, 32'h1000, 32'h2B);
      wait_done();

      // timeout on run 1; even tohost write ignored
      entry_q.push_back(8'd0);
      entry_q.push_back(8'd1);
      done_q.push_back(mk(0, 0, 1, 31'd0, 8'd1, 32'd49, 50,
         sig_step(32'h0, 32'h1000, 32'h0)));
      do_start();
      wait_run();
      wr_at(2, 32'h1000, 32'h1);
      wait_run();
      wr_at(20, 32'h1000, 32'h0);
      wait_done();

      // pass on first cycle, then pass on the timeout cycle
      entry_q.push_back(8'd0);
      entry_q.push_back(8'd1);
      done_q.push_back(mk(1, 0, 0, 31'd0, 8'd1, 32'd49, 50,
         sig_step(32'h0, 32'h1000, 32'h1)));
      do_start();
      wait_run();
      wr_at(0, 32'h1000, 32'h1);
      wait_run();
      wr_at(49, 32'h1000, 32'h1);
      wait_done();

      // fail on run 1; write during hold and start during run ignored
      entry_q.push_back(8'd0);
      entry_q.push_back(8'd1);
      done_q.push_back(mk(0, 1, 0, 31'd1, 8'd1, 32'd4, 5,
         sig_step(32'h0, 32'h1000, 32'h3)));
      do_start();
      wait_run();
      wr_at(1, 32'h1000, 32'h1);
      wr_at(0, 32'h1000, 32'h3);
      wait_run();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wr_at(3, 32'h1000, 32'h3);
      wait_done();

      // async reset mid-run
      entry_q.push_back(8'd0);
      do_start();
      wait_run();
      repeat (7) tick();
      reset = 1'b0;
      #1;
      chk_reset("mid");
      repeat (2) tick();
      reset = 1'b1;
      tick();

      // normal sequence after reset
      entry_q.push_back(8'd0);
      entry_q.push_back(8'd1);
      done_q.push_back(mk(1, 0, 0, 31'd0, 8'd1, 32'd6, 7,
         sig_step(32'h0, 32'h1000, 32'h1)));
      do_start();
      wait_run();
      wr_at(3, 32'h1000, 32'h1);
      wait_run();
      wr_at(6, 32'h1000, 32'h1);
      wait_done();

      repeat (3) tick();
      chk("entry_q_empty", 32'(entry_q.size()), 32'd0);
      chk("done_q_empty", 32'(done_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
